// File: rtl/nla_pkg.sv
// Shared constants and FSM state type for the NLA batch scheduler.
package nla_pkg;

  localparam int unsigned NLA_DATA_W     = 32;
  localparam int unsigned NLA_CNT_W      = 13;
  localparam int unsigned NLA_FIFO_DEPTH = 4096;
  localparam logic [31:0] NLA_START_WORD = 32'h7F90_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_WAIT_DONE
  } state_e;

endpackage

// File: rtl/nla_batch_scheduler_skid_buf2.sv
// Two-entry fall-through valid/ready buffer; an arriving word bypasses
// storage when the buffer is empty and the consumer takes it at once.
module nla_skid_buf2 #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o
);

  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d;
  logic              empty, pop, store, deq;

  assign empty       = (cnt_q == 2'd0);
  assign out_valid_o = !empty || in_valid_i;
  assign out_data_o  = (empty && in_valid_i) ? in_data_i : d0_q;
  assign occ_o       = cnt_q;
  assign pop         = out_valid_o && out_ready_i;
  assign store       = in_valid_i && !(empty && pop);
  assign deq         = pop && !empty;

  always_comb begin
    cnt_d = cnt_q;
    d0_d  = d0_q;
    d1_d  = d1_q;
    case ({store, deq})
      2'b10: begin
        if (empty) d0_d = in_data_i;
        else       d1_d = in_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        d0_d  = d1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          d0_d = in_data_i;
        end else begin
          d0_d = d1_q;
          d1_d = in_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= 2'd0;
      d0_q  <= '0;
      d1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      d0_q  <= d0_d;
      d1_q  <= d1_d;
    end
  end

endmodule

// File: rtl/nla_batch_scheduler.sv
// Batch sequencer: host stream -> NLA input FIFO -> engine, one batch at a time,
// delimited by a NaN start marker and closed by the engine's done pulse.
module nla_batch_scheduler
  import nla_pkg::*;
#(
  parameter int unsigned       DATA_W     = NLA_DATA_W,
  parameter int unsigned       CNT_W      = NLA_CNT_W,
  parameter logic [DATA_W-1:0] START_WORD = DATA_W'(NLA_START_WORD)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [CNT_W-1:0]  cfg_len_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              fifo_wr_en_o,
  output logic [DATA_W-1:0] fifo_data_o,
  input  logic              fifo_full_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  input  logic              eng_done_i,
  output logic              busy_o,
  output logic              batch_done_o,
  output logic              err_o
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(NLA_FIFO_DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d, wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] cfg_len_clamped;
  logic             err_q, err_d, done_q, done_d, inflight_q;
  logic             s_hs, is_marker, pop, rd_en;
  logic [1:0]       occ;
  logic [2:0]       pending;

  assign is_marker       = (s_data_i == START_WORD);
  assign cfg_len_clamped = (cfg_len_i > MAX_LEN) ? MAX_LEN : cfg_len_i;
  assign s_ready_o       = (state_q == ST_IDLE) || ((state_q == ST_FILL) && !fifo_full_i);
  assign s_hs            = s_valid_i && s_ready_o;
  assign fifo_wr_en_o    = s_hs && (state_q == ST_FILL) && !is_marker;
  assign fifo_data_o     = fifo_wr_en_o ? s_data_i : '0;

  // Reads in flight plus buffered words must never exceed the two skid slots.
  assign pop     = m_valid_o && m_ready_i;
  assign pending = 3'(inflight_q) + 3'(occ) - 3'(pop);
  assign rd_en   = (state_q == ST_DRAIN) && (rd_cnt_q != len_q) && !fifo_empty_i
                   && (pending < 3'd2);
  assign fifo_rd_en_o = rd_en;

  assign busy_o       = (state_q != ST_IDLE);
  assign batch_done_o = done_q;
  assign err_o        = err_q;

  nla_skid_buf2 #(.DATA_W(DATA_W)) u_skid (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .in_valid_i  (inflight_q),
    .in_data_i   (fifo_data_i),
    .out_ready_i (m_ready_i),
    .out_valid_o (m_valid_o),
    .out_data_o  (m_data_o),
    .occ_o       (occ)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_cnt_q;
    err_d     = err_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_hs) begin
          if (is_marker) begin
            len_d     = cfg_len_clamped;
            wr_cnt_d  = '0;
            rd_cnt_d  = '0;
            out_cnt_d = '0;
            if (cfg_len_clamped == '0) done_d = 1'b1;
            else                       state_d = ST_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (s_hs) begin
          if (is_marker) begin
            err_d   = 1'b1;
            len_d   = wr_cnt_q;
            state_d = ST_DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
            if (wr_cnt_d == len_q) state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (rd_en) rd_cnt_d = rd_cnt_q + CNT_W'(1);
        if (pop)   out_cnt_d = out_cnt_q + CNT_W'(1);
        if (out_cnt_d == len_q) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (eng_done_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (eng_done_i && (state_q != ST_WAIT_DONE)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      inflight_q <= rd_en;
    end
  end

endmodule

// File: tb/tb_nla_batch_scheduler.sv
// Scoreboard bench for nla_batch_scheduler with a behavioural 4096-deep FIFO.
module tb_nla_batch_scheduler;

  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 13;
  localparam int          DEPTH = 4096;
  localparam logic [DW-1:0] MARK = 32'h7F90_0000;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic [CW-1:0] cfg_len_i = '0;
  logic [DW-1:0] s_data_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic          fifo_wr_en_o;
  logic [DW-1:0] fifo_data_o;
  logic          fifo_full_i;
  logic          fifo_empty_i;
  logic          fifo_rd_en_o;
  logic [DW-1:0] fifo_data_i;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic          eng_done_i = 1'b0;
  logic          busy_o;
  logic          batch_done_o;
  logic          err_o;

  nla_batch_scheduler dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .cfg_len_i(cfg_len_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .fifo_wr_en_o(fifo_wr_en_o), .fifo_data_o(fifo_data_o),
    .fifo_full_i(fifo_full_i), .fifo_empty_i(fifo_empty_i),
    .fifo_rd_en_o(fifo_rd_en_o), .fifo_data_i(fifo_data_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .eng_done_i(eng_done_i), .busy_o(busy_o), .batch_done_o(batch_done_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Behavioural FIFO: registered read data, reset together with the DUT.
  logic [DW-1:0] fq[$];
  int  fcount = 0, wr_total = 0, rd_total = 0, last_wr_cyc = 0;
  bit  w_ok, r_ok;
  logic force_full = 1'b0;
  assign fifo_full_i  = (fcount >= DEPTH) || force_full;
  assign fifo_empty_i = (fcount == 0);

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fq.delete();
      fcount      <= 0;
      fifo_data_i <= '0;
    end else begin
      w_ok = fifo_wr_en_o && (fcount < DEPTH);
      r_ok = fifo_rd_en_o && (fcount > 0);
      if (r_ok) begin
        fifo_data_i <= fq.pop_front();
        rd_total    <= rd_total + 1;
      end
      if (w_ok) begin
        fq.push_back(fifo_data_o);
        wr_total    <= wr_total + 1;
        last_wr_cyc <= cyc;
      end
      fcount <= fcount + int'(w_ok) - int'(r_ok);
    end
  end

  int checks = 0, errors = 0;
  logic [DW-1:0] exp_q[$];
  int first_valid_cyc = 0, last_pop_cyc = 0;
  int ready_mode = 1;
  logic [3:0] ready_pat = 4'b1001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Pops the scoreboard on every engine handshake; checks hold while stalled.
  task automatic monitor();
    logic          prev_stall = 1'b0, prev_valid = 1'b0;
    logic [DW-1:0] prev_data = '0;
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        prev_stall = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(m_valid_o), 32'd1);
          check("stall_data", m_data_o, prev_data);
        end
        if (m_valid_o && !prev_valid) first_valid_cyc = cyc;
        if (m_valid_o && m_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_operand: got %h expected none", m_data_o);
          end else begin
            check("operand", m_data_o, exp_q.pop_front());
          end
          last_pop_cyc = cyc;
        end
        prev_stall = m_valid_o && !m_ready_i;
        prev_valid = m_valid_o;
        prev_data  = m_data_o;
      end
    end
  endtask

  task automatic ready_driver();
    int idx = 0;
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0:       m_ready_i = 1'b0;
        2: begin m_ready_i = ready_pat[idx % 4]; idx++; end
        default: m_ready_i = 1'b1;
      endcase
    end
  endtask

  task automatic send(input logic [DW-1:0] w);
    int n = 0;
    s_valid_i = 1'b1;
    s_data_i  = w;
    @(negedge clk_i);
    while (!s_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!s_ready_o) fail_bound("send_accept");
    @(posedge clk_i);
    #1;
    s_valid_i = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() != 0) fail_bound(name);
    @(posedge clk_i);
    #1;
  endtask

  task automatic finish_batch(input string tag);
    check({tag, "_busy_wait"}, 32'(busy_o), 32'd1);
    check({tag, "_done_pre"}, 32'(batch_done_o), 32'd0);
    eng_done_i = 1'b1;
    @(posedge clk_i);
    #1;
    eng_done_i = 1'b0;
    check({tag, "_done_pulse"}, 32'(batch_done_o), 32'd1);
    check({tag, "_idle"}, 32'(busy_o), 32'd0);
    @(posedge clk_i);
    #1;
    check({tag, "_done_end"}, 32'(batch_done_o), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready_o), 32'd1);
    check({tag, "_wr_en"}, 32'(fifo_wr_en_o), 32'd0);
    check({tag, "_rd_en"}, 32'(fifo_rd_en_o), 32'd0);
    check({tag, "_fifo_data"}, fifo_data_o, 32'd0);
    check({tag, "_m_valid"}, 32'(m_valid_o), 32'd0);
    check({tag, "_m_data"}, m_data_o, 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_batch_done"}, 32'(batch_done_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  task automatic run_batch4(input string tag);
    logic [DW-1:0] words [4];
    int w0, r0;
    words[0] = 32'h3F80_0000; words[1] = 32'h4000_0000;
    words[2] = 32'h4040_0000; words[3] = 32'h4080_0000;
    w0 = wr_total; r0 = rd_total;
    cfg_len_i = 13'd4;
    send(MARK);
    check({tag, "_busy_fill"}, 32'(busy_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(words[i]);
      send(words[i]);
    end
    wait_drained({tag, "_drain"});
    check({tag, "_writes"}, 32'(wr_total - w0), 32'd4);
    check({tag, "_reads"}, 32'(rd_total - r0), 32'd4);
  endtask

  initial begin
    int w0, r0;
    fork
      monitor();
      ready_driver();
    join_none

    repeat (3) @(posedge clk_i);
    #1;
    check_reset_vals("reset");
    rstn_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    // Basic batch at full throughput.
    ready_mode = 1;
    run_batch4("b4");
    check("b4_first_valid_lat", 32'(first_valid_cyc - last_wr_cyc), 32'd2);
    check("b4_back_to_back", 32'(last_pop_cyc - first_valid_cyc), 32'd3);
    finish_batch("b4");

    // Same batch with engine back-pressure.
    ready_mode = 2;
    run_batch4("stall");
    finish_batch("stall");
    ready_mode = 1;

    // Oversized length is clamped to the FIFO depth.
    w0 = wr_total; r0 = rd_total;
    cfg_len_i = 13'd5000;
    send(MARK);
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(32'h1000_0000 + 32'(i));
      send(32'h1000_0000 + 32'(i));
    end
    check("full_s_ready_low", 32'(s_ready_o), 32'd0);
    wait_drained("full_drain");
    check("full_writes", 32'(wr_total - w0), 32'd4096);
    check("full_reads", 32'(rd_total - r0), 32'd4096);
    finish_batch("full");

    // Zero-length batch: immediate done, no FIFO traffic.
    w0 = wr_total; r0 = rd_total;
    cfg_len_i = 13'd0;
    send(MARK);
    check("len0_done", 32'(batch_done_o), 32'd1);
    check("len0_busy", 32'(busy_o), 32'd0);
    @(posedge clk_i);
    #1;
    check("len0_done_end", 32'(batch_done_o), 32'd0);
    check("len0_busy_end", 32'(busy_o), 32'd0);
    check("len0_writes", 32'(wr_total - w0), 32'd0);
    check("len0_reads", 32'(rd_total - r0), 32'd0);

    // FIFO full while the host presents a word: held, not written.
    cfg_len_i = 13'd2;
    send(MARK);
    exp_q.push_back(32'hAAAA_0001);
    send(32'hAAAA_0001);
    force_full = 1'b1;
    s_valid_i  = 1'b1;
    s_data_i   = 32'hAAAA_0002;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("ff_s_ready", 32'(s_ready_o), 32'd0);
      check("ff_no_write", 32'(fifo_wr_en_o), 32'd0);
    end
    @(posedge clk_i);
    #1;
    force_full = 1'b0;
    exp_q.push_back(32'hAAAA_0002);
    send(32'hAAAA_0002);
    wait_drained("ff_drain");
    finish_batch("ff");
    check("ff_err_clear", 32'(err_o), 32'd0);

    // Marker during FILL truncates the batch and flags an error.
    w0 = wr_total; r0 = rd_total;
    cfg_len_i = 13'd5;
    send(MARK);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(32'hBBBB_0000 + 32'(i));
      send(32'hBBBB_0000 + 32'(i));
    end
    send(MARK);
    check("trunc_err", 32'(err_o), 32'd1);
    wait_drained("trunc_drain");
    check("trunc_writes", 32'(wr_total - w0), 32'd2);
    check("trunc_reads", 32'(rd_total - r0), 32'd2);
    finish_batch("trunc");

    // Reset in DRAIN with operands still pending.
    ready_mode = 0;
    cfg_len_i  = 13'd5;
    send(MARK);
    for (int i = 0; i < 5; i++) send(32'hCCCC_0000 + 32'(i));
    repeat (6) @(posedge clk_i);
    #1;
    check("rst_pre_valid", 32'(m_valid_o), 32'd1);
    check("rst_pre_busy", 32'(busy_o), 32'd1);
    rstn_i = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(posedge clk_i);
    #1;
    rstn_i     = 1'b1;
    ready_mode = 1;
    repeat (2) @(posedge clk_i);
    #1;

    // A normal batch after the reset.
    run_batch4("post");
    finish_batch("post");
    check("post_err", 32'(err_o), 32'd0);

    // Stray non-marker word while idle is dropped and flagged.
    w0 = wr_total;
    send(32'h3F80_0000);
    check("stray_err", 32'(err_o), 32'd1);
    check("stray_busy", 32'(busy_o), 32'd0);
    check("stray_writes", 32'(wr_total - w0), 32'd0);

    repeat (3) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nla_batch_scheduler.md
# nla_batch_scheduler

Sequencing controller that sits between the host operand stream, the NLA input FIFO and the nonlinear-approximation engine. It detects the NaN start marker 0x7F90_0000 and loads exactly one batch of operands into the FIFO. It then drains the FIFO into the engine with valid/ready handshaking and waits for engine completion before accepting the next batch. It owns every `wr_en`/`rd_en` strobe of the FIFO; nothing else drives them.

## Interface
Parameters:
- DATA_W, 32, operand width (IEEE-754 single).
- CNT_W, 13, batch-length counter width (FIFO depth 4096 plus one).
- START_WORD, 32'h7F90_0000, batch start marker.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- cfg_len_i  in  CNT_W  operands per batch; sampled when the marker is accepted.
- s_data_i  in  DATA_W  host operand/marker.
- s_valid_i  in  1  host word valid.
- s_ready_o  out  1  host word accepted when `s_valid_i && s_ready_o`.
- fifo_wr_en_o  out  1  FIFO write strobe.
- fifo_data_o  out  DATA_W  FIFO write data.
- fifo_full_i  in  1  FIFO full.
- fifo_empty_i  in  1  FIFO empty.
- fifo_rd_en_o  out  1  FIFO read strobe.
- fifo_data_i  in  DATA_W  FIFO read data, valid exactly 1 cycle after `fifo_rd_en_o`.
- m_data_o  out  DATA_W  operand to engine.
- m_valid_o  out  1  operand valid.
- m_ready_i  in  1  engine accepts.
- eng_done_i  in  1  engine finished last operand (single-cycle pulse).
- busy_o  out  1  state != IDLE.
- batch_done_o  out  1  one-cycle pulse at batch end.
- err_o  out  1  sticky protocol error; cleared only by reset.

## Operation
FSM states: IDLE, FILL, DRAIN, WAIT_DONE.
- IDLE:
  - `s_ready_o`=1.
  - A non-marker word is consumed and discarded; it sets `err_o`.
  - A marker word is consumed (never written to the FIFO) and `len` is latched from `cfg_len_i`.
    - `len`==0: pulse `batch_done_o` next cycle, stay in IDLE.
    - Otherwise go to FILL with `wr_cnt`=0.
- FILL:
  - `s_ready_o` = !fifo_full_i.
  - On handshake: `fifo_wr_en_o`=1, `fifo_data_o`=s_data_i (combinational pass-through), `wr_cnt`++.
  - When `wr_cnt` reaches `len` → DRAIN.
  - A marker during FILL is consumed, not written, and sets `err_o`. `len` is truncated to `wr_cnt` and the FSM goes to DRAIN.
- DRAIN:
  - `s_ready_o`=0.
  - Reads are issued into a 2-entry output skid buffer. `fifo_rd_en_o`=1 when all of: `rd_cnt`<`len`, !fifo_empty_i, and (`inflight` + `buffered` − pop-this-cycle) < 2.
  - Each read increments `rd_cnt`. Data lands in the buffer the next cycle.
  - `m_data_o`/`m_valid_o` come from the buffer head; a pop occurs on `m_valid_o && m_ready_i`.
  - When `out_cnt`==`len` → WAIT_DONE.
- WAIT_DONE: on `eng_done_i`, pulse `batch_done_o` and go to IDLE. `eng_done_i` in any other state sets `err_o` and is otherwise ignored.
- Counters are CNT_W wide, compare-equal only, and never wrap within a batch. `cfg_len_i` > 4096 is clamped to 4096.
- Reset mid-operation:
  - All state returns to IDLE and counters to 0.
  - The FIFO is reset by the same `rstn_i`, so no residue remains.

## Timing
- Reset values: `s_ready_o`=1, `fifo_wr_en_o`=0, `fifo_rd_en_o`=0, `fifo_data_o`=0, `m_valid_o`=0, `m_data_o`=0, `busy_o`=0, `batch_done_o`=0, `err_o`=0.
- Marker accepted at edge N → FILL at N+1; the first operand can be written in cycle N+1.
- Last write at edge N → DRAIN at N+1. First `fifo_rd_en_o` in cycle N+1; `m_valid_o` first high in cycle N+2.
- Throughput is 1 operand/cycle when `m_ready_i` is held high. `m_data_o` is stable while `m_valid_o && !m_ready_i`.
- `batch_done_o` is registered, 1 cycle after `eng_done_i`.
- Simultaneous `fifo_full_i` and `s_valid_i`: no write; the word is held by the host.

## Structure
- Shared package `nla_pkg`: START_WORD constant, FSM state enum, CNT_W/DATA_W defaults.
- One sub-module, `nla_skid_buf2`: 2-entry valid/ready buffer with occupancy output, used for the DRAIN path.

## Test plan
- Marker, then 4 words (1.0, 2.0, 3.0, 4.0 as hex), `len`=4, `m_ready_i`=1 → 4 FIFO writes; `m_data_o` sequence 3F800000, 40000000, 40400000, 40800000 on consecutive cycles; `batch_done_o` 1 cycle after `eng_done_i`.
- Same batch with `m_ready_i` toggling 1,0,0,1,… → no operand lost or duplicated; `m_data_o` stable while stalled.
- `len`=4096, `fifo_full_i` asserted after 4096 writes → `s_ready_o` low only when full; exactly 4096 reads issued, then WAIT_DONE.
- Marker mid-FILL after 2 of 5 words → `err_o`=1, exactly 2 operands drained, `batch_done_o` after `eng_done_i`.
- `len`=0 → `batch_done_o` pulse 1 cycle after the marker; no FIFO strobes; `busy_o` stays 0.
- `rstn_i` asserted in DRAIN with 3 operands pending → all outputs at reset values immediately; the next batch runs normally.
